// File: rtl/lsb_bit_walker.sv
// Set-bit enumerator: captures a word, then streams the index of each set bit,
// lowest first, over a valid/ready handshake while clearing it from the residual.
module lsb_bit_walker #(
  parameter  int WIDTH = 32,
  localparam int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic             load,
  output logic             busy,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic [IDXW-1:0]  idx,
  output logic             idx_last,
  output logic [WIDTH-1:0] remain,
  output logic [IDXW:0]    count,
  output logic             done
);

  localparam int CW = IDXW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] remain_q, remain_d;
  logic [CW-1:0]    count_q, count_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] remain_cleared;
  logic [IDXW-1:0]  lowest_idx;
  logic             single_bit;
  logic             in_run;
  logic             beat_accept;

  // Residual with its lowest set bit removed; zero means that bit was the last one.
  assign remain_cleared = remain_q & (remain_q - WIDTH'(1));
  assign single_bit     = (remain_cleared == '0);
  assign in_run         = (state_q == RUN);
  assign beat_accept    = in_run && idx_ready;

  // Count-trailing-zeros: scanning high to low lets the lowest set bit win.
  // NOTE: every variable written in always_comb gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    lowest_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (remain_q[i]) begin
        lowest_idx = IDXW'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    count_d  = count_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load) begin
          remain_d = in1;
          count_d  = '0;
          if (in1 != '0) begin
            state_d = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      RUN: begin
        // load is deliberately ignored here: a walk in progress is never restarted.
        if (beat_accept) begin
          remain_d = remain_cleared;
          count_d  = count_q + CW'(1);
          if (single_bit) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      remain_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      count_q  <= count_d;
      done_q   <= done_d;
    end
  end

  // Index outputs are forced to zero outside RUN so consumers never see stale data.
  assign busy      = in_run;
  assign idx_valid = in_run;
  assign idx       = in_run ? lowest_idx : '0;
  assign idx_last  = in_run && single_bit;
  assign remain    = remain_q;
  assign count     = count_q;
  assign done      = done_q;

endmodule

// File: tb/tb_lsb_bit_walker.sv
// Self-checking bench for lsb_bit_walker: directed scenarios plus random words,
// compared against a queue-of-indices reference model built from each loaded word.
module tb_lsb_bit_walker;

  localparam int WIDTH = 32;
  localparam int IDXW  = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in1;
  logic             load;
  logic             busy;
  logic             idx_valid;
  logic             idx_ready;
  logic [IDXW-1:0]  idx;
  logic             idx_last;
  logic [WIDTH-1:0] remain;
  logic [IDXW:0]    count;
  logic             done;

  int n_checks = 0;
  int n_errors = 0;

  bit ready_pat [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  int pat_pos;

  always #5 clk = ~clk;

  lsb_bit_walker #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in1       (in1),
    .load      (load),
    .busy      (busy),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .idx       (idx),
    .idx_last  (idx_last),
    .remain    (remain),
    .count     (count),
    .done      (done)
  );

  // Loads one word and walks it to completion. mode: 0 ready high, 1 random ready,
  // 2 the fixed ready pattern. Ends in the cycle where done is high; with settle
  // set it then idles one cycle and checks that done was a single-cycle pulse.
  task automatic stream_word(input logic [WIDTH-1:0] word, input int mode,
                             input bit inject_load, input bit settle, input string name);
    int               exp_q[$];
    logic [WIDTH-1:0] exp_rem;
    logic [WIDTH-1:0] first_rem;
    int               k;
    int               cycles;
    bit               r;

    for (int i = 0; i < WIDTH; i++) if (word[i]) exp_q.push_back(i);
    exp_rem   = word;
    first_rem = word ^ (word & -word);
    k         = 0;
    cycles    = 0;

    in1 = word; load = 1'b1; idx_ready = 1'b0;
    @(posedge clk); #1;
    load = 1'b0; in1 = $urandom;

    n_checks++;
    if (busy !== (word != '0)) begin n_errors++; $display("FAIL %s load busy: got %0b want %0b", name, busy, word != '0); end
    n_checks++;
    if (remain !== word) begin n_errors++; $display("FAIL %s load remain: got %h want %h", name, remain, word); end
    n_checks++;
    if (count !== '0) begin n_errors++; $display("FAIL %s load count: got %0d want 0", name, count); end

    if (exp_q.size() == 0) begin
      n_checks++;
      if (done !== 1'b1) begin n_errors++; $display("FAIL %s empty done: got %0b want 1", name, done); end
      n_checks++;
      if (idx_valid !== 1'b0) begin n_errors++; $display("FAIL %s empty idx_valid: got %0b want 0", name, idx_valid); end
    end else begin
      while (exp_q.size() != 0 && cycles < 600) begin
        case (mode)
          0:       r = 1'b1;
          1:       r = 1'($urandom_range(0, 1));
          default: begin r = ready_pat[pat_pos % 6]; pat_pos++; end
        endcase
        idx_ready = r;
        if (inject_load && k == 1) begin load = 1'b1; in1 = 32'h0000_0001; end
        else load = 1'b0;

        n_checks++;
        if (idx_valid !== 1'b1 || busy !== 1'b1) begin
          n_errors++; $display("FAIL %s beat%0d valid/busy: got %0b/%0b want 1/1", name, k, idx_valid, busy);
        end
        n_checks++;
        if (idx !== IDXW'(exp_q[0])) begin n_errors++; $display("FAIL %s beat%0d idx: got %0d want %0d", name, k, idx, exp_q[0]); end
        n_checks++;
        if (idx_last !== (exp_q.size() == 1)) begin
          n_errors++; $display("FAIL %s beat%0d idx_last: got %0b want %0b", name, k, idx_last, exp_q.size() == 1);
        end
        n_checks++;
        if (remain !== exp_rem) begin n_errors++; $display("FAIL %s beat%0d remain: got %h want %h", name, k, remain, exp_rem); end
        n_checks++;
        if (count !== (IDXW+1)'(k)) begin n_errors++; $display("FAIL %s beat%0d count: got %0d want %0d", name, k, count, k); end
        n_checks++;
        if (done !== 1'b0) begin n_errors++; $display("FAIL %s beat%0d done: got %0b want 0", name, k, done); end

        @(posedge clk); #1;
        cycles++;
        if (r) begin
          exp_rem[exp_q[0]] = 1'b0;
          void'(exp_q.pop_front());
          k++;
          if (k == 1) begin
            n_checks++;
            if (remain !== first_rem) begin n_errors++; $display("FAIL %s first-accept remain: got %h want %h", name, remain, first_rem); end
          end
        end
      end
      load = 1'b0; idx_ready = 1'b0;

      if (exp_q.size() != 0) begin
        n_errors++; $display("FAIL %s timeout: %0d beats outstanding after %0d cycles", name, exp_q.size(), cycles);
      end else begin
        n_checks++;
        if (done !== 1'b1) begin n_errors++; $display("FAIL %s end done: got %0b want 1", name, done); end
        n_checks++;
        if (busy !== 1'b0 || idx_valid !== 1'b0 || idx !== '0 || idx_last !== 1'b0) begin
          n_errors++; $display("FAIL %s end idle outputs: busy %0b valid %0b idx %0d last %0b want all 0", name, busy, idx_valid, idx, idx_last);
        end
        n_checks++;
        if (count !== (IDXW+1)'($countones(word))) begin
          n_errors++; $display("FAIL %s end count: got %0d want %0d", name, count, $countones(word));
        end
        n_checks++;
        if (remain !== '0) begin n_errors++; $display("FAIL %s end remain: got %h want 0", name, remain); end
      end
    end

    if (settle) begin
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_errors++; $display("FAIL %s settle done/busy: got %0b/%0b want 0/0", name, done, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; in1 = '0; idx_ready = 1'b0;
    #3;
    n_checks++;
    if ({busy, idx_valid, idx, idx_last, remain, count, done} !== '0) begin
      n_errors++; $display("FAIL reset outputs: busy %0b valid %0b idx %0d last %0b remain %h count %0d done %0b want all 0",
                           busy, idx_valid, idx, idx_last, remain, count, done);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_empty();
    stream_word(32'h0000_0000, 0, 1'b0, 1'b1, "empty");
  endtask

  task automatic test_extremes();
    stream_word(32'h8000_0001, 0, 1'b0, 1'b1, "extremes");
  endtask

  task automatic test_full();
    stream_word(32'hFFFF_FFFF, 0, 1'b0, 1'b1, "full");
  endtask

  task automatic test_backpressure();
    pat_pos = 0;
    stream_word(32'h0000_00A4, 2, 1'b0, 1'b1, "backpressure");
  endtask

  task automatic test_load_while_busy();
    stream_word(32'h0000_0F00, 0, 1'b1, 1'b1, "load_busy");
  endtask

  task automatic test_back_to_back();
    stream_word(32'h0000_0041, 0, 1'b0, 1'b0, "b2b_first");
    stream_word(32'h8000_0000, 0, 1'b0, 1'b1, "b2b_second");
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] w;
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 4))
        0:       w = $urandom & $urandom & $urandom;
        1:       w = $urandom | $urandom;
        2:       w = (n % 25 == 0) ? '0 : (32'h1 << $urandom_range(0, 31));
        default: w = $urandom;
      endcase
      stream_word(w, 1, 1'b0, 1'($urandom_range(0, 1)), "random");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    in1 = 32'h0000_00FF; load = 1'b1; idx_ready = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (idx !== 5'd1 || idx_valid !== 1'b1) begin
      n_errors++; $display("FAIL rst_mid beat2: got idx %0d valid %0b want 1/1", idx, idx_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, idx_valid, idx, idx_last, remain, count, done} !== '0) begin
      n_errors++; $display("FAIL rst_mid async outputs: busy %0b valid %0b idx %0d last %0b remain %h count %0d done %0b want all 0",
                           busy, idx_valid, idx, idx_last, remain, count, done);
    end
    idx_ready = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || remain !== '0) begin
      n_errors++; $display("FAIL rst_mid after release: busy %0b remain %h want 0/0", busy, remain);
    end
    stream_word(32'h0000_0010, 0, 1'b0, 1'b1, "post_reset");
  endtask

  initial begin
    test_reset();
    test_empty();
    test_extremes();
    test_full();
    test_backpressure();
    test_load_while_busy();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsb_bit_walker.md
# lsb_bit_walker

Sequential set-bit enumerator: captures a WIDTH-bit word and streams the index of every set bit, lowest first, over a valid/ready handshake. Each accepted beat clears the lowest set bit of the residual word (x & (x-1)). It is the consuming end of the clear-lowest-set-bit datapath: that block produces the residual, this block walks the residual down to zero and reports each removed bit position. It feeds index-driven consumers such as an interrupt dispatcher or a sparse-mask scheduler.

## Interface

Parameters:
- WIDTH, 32, width of the loaded word; power of two, at least 2
- IDXW, $clog2(WIDTH), index width (derived, do not override)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in1  input  WIDTH  word to enumerate; sampled when load is accepted
- load  input  1  capture request; accepted only in IDLE
- busy  output  1  high while in RUN
- idx_valid  output  1  index beat available
- idx_ready  input  1  downstream accepts beat
- idx  output  IDXW  position of lowest set bit of remain
- idx_last  output  1  current beat is the final set bit
- remain  output  WIDTH  residual word (bits not yet emitted)
- count  output  IDXW+1  beats accepted since last load
- done  output  1  one-cycle pulse when enumeration completes

## Operation

- States: IDLE and RUN. Reset enters IDLE.
- Reset values: busy=0, idx_valid=0, idx=0, idx_last=0, remain=0, count=0, done=0.
- IDLE, load=1:
  - remain<=in1 and count<=0.
  - If in1!=0, go to RUN.
  - If in1==0, stay in IDLE and pulse done the next cycle (empty word, no beats).
- RUN:
  - idx_valid=1.
  - idx = count-trailing-zeros(remain), decoded combinationally from the remain register.
  - idx_last=1 when remain has exactly one bit set, i.e. (remain & (remain-1))==0.
- Beat accept (idx_valid & idx_ready):
  - remain<=remain & (remain-1) and count<=count+1.
  - If idx_last, go to IDLE and assert done for the following cycle.
- idx_ready low: hold idx, idx_last, remain and count stable.
- load in RUN is ignored; no capture and no restart.
- Outside RUN, idx and idx_last are 0.
- count is IDXW+1 bits wide, so count=WIDTH (32) holds without wrap.
- remain after the first accepted beat equals in1 ^ (in1 & -in1).

## Timing

- load is sampled at a rising edge. busy and idx_valid rise on that same edge.
- First beat is offered in the cycle after load.
- Throughput is one beat per cycle while idx_ready=1.
- With ready held high, a word with N set bits gives N consecutive valid cycles, then done one cycle after the last accept.
- After done, load is accepted in the same cycle that done is high, because the block is already in IDLE.
- Async reset mid-RUN immediately forces all outputs to reset values and drops any in-flight beat.
- There is no combinational path from idx_ready to idx_valid. idx is combinational from remain only.

## Test plan

- Empty word: load in1=0x00000000 -> no idx_valid; done pulses 1 cycle after load; count=0; busy stays 0.
- Two extremes: load 0x80000001, ready=1 -> beats idx=0 (last=0), then idx=31 (last=1); done next cycle; count=2; remain=0.
- Full word: load 0xFFFFFFFF, ready=1 -> 32 consecutive beats idx=0..31, idx_last only on 31; count=32 at done.
- Backpressure: load 0x000000A4, ready pattern 0,1,0,0,1,1 -> idx 2, 5, 7 each held stable while ready=0; remain steps 0xA4 -> 0xA0 -> 0x80 -> 0; done after idx=7 is accepted.
- Load while busy: load 0x00000F00, then pulse load with 0x00000001 during RUN -> pulse ignored; beats 8, 9, 10, 11 only.
- Random 200 words: after first accept, remain == in1 ^ (in1 & -in1); count at done == popcount(in1).
- Reset mid-run: assert rst_n=0 during beat 2 of 0x000000FF -> all outputs 0 immediately; after release, load 0x10 gives single beat idx=4 with last=1.
